// File: rtl/program_loader_pkg.sv
// Shared types for the byte-stream bootloader: FSM state encoding, frame
// length type and the default frame start marker.
// Optional feature macro used by importers: PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

  // Default frame start marker; the top exposes it as an overridable parameter.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame length field as carried on the wire (little-endian, two bytes).
  typedef logic [15:0] frame_len_t;

  // Loader FSM states. CHECK is only reachable in checksum builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    DATA   = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// Purpose : 8-bit modular accumulator for the payload checksum.
// Latency : sum reflects an add one cycle after add is asserted.
// Backpressure: none; the caller qualifies add with its own handshake.
// Ports   : clk, rst_n (async active-low), clear (zero the sum, wins over add),
//           add (accumulate data this cycle), data [7:0], sum [7:0].
module loader_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (add) begin
      // Natural 8-bit wrap gives the mod-256 sum.
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Purpose : byte-stream bootloader; parses SYNC/len/payload[/checksum] frames
//           and writes the payload into program memory, holding the CPU until
//           a complete image is in place.
// Latency : a payload byte accepted at cycle N is written at cycle N+1.
// Backpressure: rx_ready is a pure function of state; one byte per cycle max.
// Ports   : clk, rst_n (async active-low), start (arm; only sampled in
//           IDLE/DONE/ERROR), rx_data/rx_valid/rx_ready (byte handshake),
//           mem_write_enable/mem_write_data/mem_write_address (byte write
//           port), cpu_hold, load_done, load_error, bytes_written.
// Option  : define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum
//           byte (sum of payload mod 256) before the image is declared done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_write_enable,
  output logic [7:0]  mem_write_data,
  output logic [31:0] mem_write_address,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] bytes_written
);

  // Largest legal length, one bit wider than the field so 65535 compares cleanly.
  localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

  // Where the FSM goes once the payload is exhausted (or was empty).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = CHECK;
`else
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t     state;
  state_t     next_state;
  logic [7:0] len_lo;
  frame_len_t frame_len;
  frame_len_t len_rx;
  logic       accept;
  logic       data_accept;
  logic       last_byte;
  logic       arm;
  logic       clear_frame;

  assign accept      = rx_valid && rx_ready;
  assign data_accept = accept && (state == DATA);
  assign len_rx      = {rx_data, len_lo};
  // bytes_written doubles as the write index, so it counts bytes before this one.
  assign last_byte   = (bytes_written + 16'd1) == frame_len;
  assign clear_frame = arm || (state == IDLE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  loader_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_frame),
    .add   (data_accept),
    .data  (rx_data),
    .sum   (checksum)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    arm        = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          next_state = SYNC;
          arm        = 1'b1;
        end
      end
      SYNC: begin
        rx_ready = 1'b1;
        // Anything other than the marker is line noise and is dropped.
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          next_state = LEN_LO;
        end
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          next_state = LEN_HI;
        end
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if ({1'b0, len_rx} > MAX_LEN) begin
            next_state = ERROR;
          end else if (len_rx == 16'd0) begin
            next_state = PAYLOAD_END;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && last_byte) begin
          next_state = PAYLOAD_END;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        // The last payload add lands the cycle the FSM enters CHECK, so the
        // sum is already complete by the earliest possible checksum accept.
        if (rx_valid) begin
          next_state = (rx_data == checksum) ? DONE : ERROR;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Length capture and the registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo            <= 8'h00;
      frame_len         <= 16'd0;
      mem_write_enable  <= 1'b0;
      mem_write_data    <= 8'h00;
      mem_write_address <= BASE_ADDR;
      bytes_written     <= 16'd0;
    end else begin
      // Strobe defaults low so each accepted byte yields exactly one write cycle.
      mem_write_enable <= 1'b0;
      if (clear_frame) begin
        bytes_written <= 16'd0;
      end
      if (accept && (state == LEN_LO)) begin
        len_lo <= rx_data;
      end
      if (accept && (state == LEN_HI)) begin
        frame_len <= len_rx;
      end
      if (data_accept) begin
        mem_write_enable  <= 1'b1;
        mem_write_data    <= rx_data;
        mem_write_address <= BASE_ADDR + {16'd0, bytes_written};
        bytes_written     <= bytes_written + 16'd1;
      end
    end
  end

  // Done is withheld while the final write strobe is still on the bus, so the
  // CPU is only released once every payload byte has reached memory.
  assign load_done  = (state == DONE) && !mem_write_enable;
  assign cpu_hold   = !load_done;
  assign load_error = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal frame, (bad checksum), oversize,
// zero length with preamble noise, throttled payload with ignored start
// pulses, boundary length and reset mid-payload followed by a clean reload.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_write_enable;
  logic [7:0]  mem_write_data;
  logic [31:0] mem_write_address;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] bytes_written;

  int vectors;
  int miscompares;

  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  pl[$];

  program_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .mem_write_enable  (mem_write_enable),
    .mem_write_data    (mem_write_data),
    .mem_write_address (mem_write_address),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_error        (load_error),
    .bytes_written     (bytes_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe seen between clock edges.
  always @(negedge clk) begin
    if (rst_n && mem_write_enable) begin
      wr_addr.push_back(mem_write_address);
      wr_data.push_back(mem_write_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one byte for one cycle; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Full frame from queue pl, back-to-back bytes, with a correct checksum.
  task automatic send_frame();
    logic [15:0] n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    n = 16'(pl.size());
    send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
    foreach (pl[i]) begin
      send(pl[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum = sum + pl[i];
`endif
    end
    if (n != 16'd0) check("done_low_during_last_write", {31'd0, load_done}, 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(sum);
`endif
    step();
  endtask

  // Compare logged writes against pl at consecutive addresses from BASE.
  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(wr_addr.size()), 32'(pl.size()));
    for (int i = 0; i < pl.size() && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], BASE + 32'(i));
      check({tag, "_data"}, {24'd0, wr_data[i]}, {24'd0, pl[i]});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
    check({tag, "_wdata"}, {24'd0, mem_write_data}, 32'd0);
    check({tag, "_waddr"}, mem_write_address, BASE);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_error"}, {31'd0, load_error}, 32'd0);
    check({tag, "_bytes"}, {16'd0, bytes_written}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    #2;
    check_reset_values("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Normal frame: four payload bytes at addresses 0..3.
    clear_log();
    pulse_start();
    check("sync_rx_ready", {31'd0, rx_ready}, 32'd1);
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame();
    check("normal_done", {31'd0, load_done}, 32'd1);
    check("normal_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("normal_error", {31'd0, load_error}, 32'd0);
    check("normal_bytes", {16'd0, bytes_written}, 32'd4);
    check("normal_rx_ready", {31'd0, rx_ready}, 32'd0);
    check_writes("normal");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, image rejected.
    clear_log();
    pulse_start();
    send(8'hA5); send(8'h04); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h14);
    step();
    check("badsum_error", {31'd0, load_error}, 32'd1);
    check("badsum_done", {31'd0, load_done}, 32'd0);
    check("badsum_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_writes("badsum");
`endif

    // Oversize: len 1025 rejected right after the high length byte.
    clear_log();
    pulse_start();
    check("rearm_done_cleared", {31'd0, load_done}, 32'd0);
    check("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send(8'hA5); send(8'h01); send(8'h04);
    check("oversize_error", {31'd0, load_error}, 32'd1);
    check("oversize_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("oversize_rx_ready", {31'd0, rx_ready}, 32'd0);
    step();
    check("oversize_writes", 32'(wr_addr.size()), 32'd0);

    // Zero length preceded by noise bytes.
    clear_log();
    pulse_start();
    check("rearm_error_cleared", {31'd0, load_error}, 32'd0);
    send(8'hFF);
    send(8'h00);
    check("noise_still_sync", {31'd0, rx_ready}, 32'd1);
    pl = '{};
    send_frame();
    check("zero_done", {31'd0, load_done}, 32'd1);
    check("zero_bytes", {16'd0, bytes_written}, 32'd0);
    check("zero_writes", 32'(wr_addr.size()), 32'd0);

    // Throttled payload with start pulses in the gaps.
    clear_log();
    pulse_start();
    send(8'hA5); send(8'h03); send(8'h00);
    send(8'h11);
    check("thr0_we", {31'd0, mem_write_enable}, 32'd1);
    check("thr0_data", {24'd0, mem_write_data}, 32'h11);
    check("thr0_addr", mem_write_address, BASE);
    pulse_start();
    check("thr_gap0_we", {31'd0, mem_write_enable}, 32'd0);
    check("thr_gap0_ready", {31'd0, rx_ready}, 32'd1);
    check("thr_gap0_bytes", {16'd0, bytes_written}, 32'd1);
    send(8'h22);
    check("thr1_we", {31'd0, mem_write_enable}, 32'd1);
    check("thr1_data", {24'd0, mem_write_data}, 32'h22);
    check("thr1_addr", mem_write_address, BASE + 32'd1);
    pulse_start();
    check("thr_gap1_we", {31'd0, mem_write_enable}, 32'd0);
    send(8'h33);
    check("thr2_we", {31'd0, mem_write_enable}, 32'd1);
    check("thr2_data", {24'd0, mem_write_data}, 32'h33);
    check("thr2_addr", mem_write_address, BASE + 32'd2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send(8'h66);
`endif
    step();
    check("thr_done", {31'd0, load_done}, 32'd1);
    check("thr_bytes", {16'd0, bytes_written}, 32'd3);
    check("thr_writes", 32'(wr_addr.size()), 32'd3);

    // Boundary length 1024 is accepted; reset after two payload bytes.
    clear_log();
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h04);
    check("len1024_error", {31'd0, load_error}, 32'd0);
    check("len1024_ready", {31'd0, rx_ready}, 32'd1);
    send(8'hAA);
    send(8'hBB);
    check("mid_addr", mem_write_address, BASE + 32'd1);
    check("mid_bytes", {16'd0, bytes_written}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    step();
    rst_n = 1'b1;
    step();

    // Clean reload after the aborted frame.
    clear_log();
    pulse_start();
    pl = '{8'h5A, 8'hC3};
    send_frame();
    check("reload_done", {31'd0, load_done}, 32'd1);
    check("reload_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("reload_bytes", {16'd0, bytes_written}, 32'd2);
    check_writes("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
